// File: rtl/float_stream_feeder_if.sv
// float_stream_feeder_if
// Bus bundle for float_stream_feeder: Avalon-MM control slave, memory read
// master and accumulator master, plus the level interrupt.
//   ctl_*  : control slave (word address, 0-latency combinational read data)
//   mem_*  : memory read master (byte address, waitrequest stall)
//   acc_*  : accumulator master (address 0 = data, 1 = accumulator/result)
//   irq    : level interrupt, high while done is set
// Modports:
//   master : feeder side (drives the memory/accumulator masters)
//   slave  : environment side (CPU, memory and accumulator models)
interface float_stream_feeder_if;
  logic [1:0]  ctl_address;
  logic        ctl_write;
  logic        ctl_read;
  logic [31:0] ctl_writedata;
  logic [31:0] ctl_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        acc_address;
  logic        acc_write;
  logic        acc_read;
  logic [31:0] acc_writedata;
  logic [31:0] acc_readdata;
  logic        acc_waitrequest;
  logic        irq;

  modport master (
    input  ctl_address, ctl_write, ctl_read, ctl_writedata,
    input  mem_readdata, mem_waitrequest, acc_readdata, acc_waitrequest,
    output ctl_readdata, mem_address, mem_read,
    output acc_address, acc_write, acc_read, acc_writedata, irq
  );

  modport slave (
    output ctl_address, ctl_write, ctl_read, ctl_writedata,
    output mem_readdata, mem_waitrequest, acc_readdata, acc_waitrequest,
    input  ctl_readdata, mem_address, mem_read,
    input  acc_address, acc_write, acc_read, acc_writedata, irq
  );
endinterface

// File: rtl/float_stream_feeder.sv
// float_stream_feeder
// Runs one accumulator job per start: clear the accumulator, stream LEN
// single-precision words from BASE into its data port, read the result back,
// latch it in RESULT and raise irq.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : float_stream_feeder_if.master (control slave, memory master,
//           accumulator master, irq)
// Registers: 0 BASE (RW, [1:0]=0), 1 LEN (RW, LEN_W bits), 2 CTRL/STATUS
// (W: bit0 start, bit1 clear done; R: bit0 busy, bit1 done), 3 RESULT (RO).
// Build option: FEEDER_PREFETCH_EN adds a 2-entry FIFO so fetches and pushes
// overlap (1 element/cycle); undefined gives strict FETCH/PUSH alternation.
module float_stream_feeder #(
  parameter int LEN_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  float_stream_feeder_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_PUSH, S_STREAM, S_RES, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d, result_q, result_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic             done_q, done_d;
  logic             busy;

  // Master outputs are all registered; *_d is what the next cycle shows.
  logic             mem_read_q, mem_read_d;
  logic             acc_write_q, acc_write_d;
  logic             acc_read_q, acc_read_d;
  logic             acc_address_q, acc_address_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [31:0]      acc_writedata_q, acc_writedata_d;

`ifdef FEEDER_PREFETCH_EN
  // Shift-style 2-entry FIFO: f0 is always the head.
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      f0_q, f0_d, f1_q, f1_d;
  logic [LEN_W-1:0] pushed_q, pushed_d;
  logic             pop, push;
`endif

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    len_d           = len_q;
    result_d        = result_q;
    done_d          = done_q;
    idx_d           = idx_q;
    mem_read_d      = 1'b0;
    acc_write_d     = 1'b0;
    acc_read_d      = 1'b0;
    mem_address_d   = mem_address_q;
    acc_address_d   = acc_address_q;
    acc_writedata_d = acc_writedata_q;
`ifdef FEEDER_PREFETCH_EN
    cnt_d    = cnt_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    pushed_d = pushed_q;
    pop      = 1'b0;
    push     = 1'b0;
`endif

    // Control writes; configuration is frozen while a job runs.
    if (bus.ctl_write) begin
      unique case (bus.ctl_address)
        2'd0: if (!busy) base_d = {bus.ctl_writedata[31:2], 2'b00};
        2'd1: if (!busy) len_d = bus.ctl_writedata[LEN_W-1:0];
        2'd2: begin
          if (bus.ctl_writedata[1]) done_d = 1'b0;
          if (bus.ctl_writedata[0] && !busy) begin
            done_d  = 1'b0;
            state_d = S_CLR;
          end
        end
        default: ;
      endcase
    end

    unique case (state_q)
      S_CLR: if (!bus.acc_waitrequest) begin
        idx_d = '0;
        if (len_q == '0) state_d = S_RES;
`ifdef FEEDER_PREFETCH_EN
        else begin
          cnt_d    = 2'd0;
          pushed_d = '0;
          state_d  = S_STREAM;
        end
`else
        else state_d = S_FETCH;
`endif
      end
`ifdef FEEDER_PREFETCH_EN
      S_STREAM: begin
        pop   = acc_write_q && !bus.acc_waitrequest;
        push  = mem_read_q && !bus.mem_waitrequest;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
        if (push && pop) begin
          if (cnt_q == 2'd1) f0_d = bus.mem_readdata;
          else begin
            f0_d = f1_q;
            f1_d = bus.mem_readdata;
          end
        end else if (pop) begin
          f0_d = f1_q;
        end else if (push) begin
          if (cnt_q == 2'd0) f0_d = bus.mem_readdata;
          else f1_d = bus.mem_readdata;
        end
        if (push) idx_d = idx_q + LEN_W'(1);
        if (pop) pushed_d = pushed_q + LEN_W'(1);
        // All fetches precede their pushes, so LEN pushes means FIFO empty.
        if (pushed_d == len_q) state_d = S_RES;
      end
`else
      S_FETCH: if (!bus.mem_waitrequest) begin
        acc_writedata_d = bus.mem_readdata;
        state_d         = S_PUSH;
      end
      S_PUSH: if (!bus.acc_waitrequest) begin
        idx_d   = idx_q + LEN_W'(1);
        state_d = (idx_d == len_q) ? S_RES : S_FETCH;
      end
`endif
      S_RES: if (!bus.acc_waitrequest) begin
        result_d = bus.acc_readdata;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // Strobes follow the state being entered; a stalled state re-derives the
    // same address/data, which keeps them stable under waitrequest.
    unique case (state_d)
      S_CLR: begin
        acc_write_d     = 1'b1;
        acc_address_d   = 1'b1;
        acc_writedata_d = '0;
      end
`ifdef FEEDER_PREFETCH_EN
      S_STREAM: begin
        mem_read_d = (idx_d < len_q) && (cnt_d != 2'd2);
        if (mem_read_d) mem_address_d = base_q + (32'(idx_d) << 2);
        acc_write_d     = (cnt_d != 2'd0);
        acc_address_d   = 1'b0;
        acc_writedata_d = f0_d;
      end
`else
      S_FETCH: begin
        mem_read_d    = 1'b1;
        mem_address_d = base_q + (32'(idx_d) << 2);
      end
      S_PUSH: begin
        acc_write_d   = 1'b1;
        acc_address_d = 1'b0;
      end
`endif
      S_RES: begin
        acc_read_d    = 1'b1;
        acc_address_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      result_q        <= '0;
      done_q          <= 1'b0;
      idx_q           <= '0;
      mem_read_q      <= 1'b0;
      acc_write_q     <= 1'b0;
      acc_read_q      <= 1'b0;
      acc_address_q   <= 1'b0;
      mem_address_q   <= '0;
      acc_writedata_q <= '0;
`ifdef FEEDER_PREFETCH_EN
      cnt_q           <= '0;
      f0_q            <= '0;
      f1_q            <= '0;
      pushed_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      len_q           <= len_d;
      result_q        <= result_d;
      done_q          <= done_d;
      idx_q           <= idx_d;
      mem_read_q      <= mem_read_d;
      acc_write_q     <= acc_write_d;
      acc_read_q      <= acc_read_d;
      acc_address_q   <= acc_address_d;
      mem_address_q   <= mem_address_d;
      acc_writedata_q <= acc_writedata_d;
`ifdef FEEDER_PREFETCH_EN
      cnt_q           <= cnt_d;
      f0_q            <= f0_d;
      f1_q            <= f1_d;
      pushed_q        <= pushed_d;
`endif
    end
  end

  // Zero-latency register read.
  always_comb begin
    bus.ctl_readdata = '0;
    if (bus.ctl_read) begin
      unique case (bus.ctl_address)
        2'd0:    bus.ctl_readdata = base_q;
        2'd1:    bus.ctl_readdata = 32'(len_q);
        2'd2:    bus.ctl_readdata = {30'd0, done_q, busy};
        default: bus.ctl_readdata = result_q;
      endcase
    end
  end

  assign bus.mem_address   = mem_address_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.acc_address   = acc_address_q;
  assign bus.acc_write     = acc_write_q;
  assign bus.acc_read      = acc_read_q;
  assign bus.acc_writedata = acc_writedata_q;
  assign bus.irq           = done_q;
endmodule

// File: tb/tb_float_stream_feeder.sv
`timescale 1ns/1ps
module tb_float_stream_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  float_stream_feeder_if bus();
  float_stream_feeder #(.LEN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0, n_err = 0;
  int cyc = 0, c0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] memarr [logic [31:0]];
  logic [31:0] acc_res = '0;
  int acc_mode = 0, res_stall_n = 0, res_stall_cnt = 0;
  bit mem_rand = 1'b0;

  // Scoreboard: expected pushed with stimulus, observed logged on accept.
  logic [32:0] exp_acc[$], obs_acc[$];
  logic [31:0] exp_mem[$], obs_mem[$];
  int obs_res_n = 0, clr_rel = -1, fetch0_rel = -1, proto_err = 0;

  // Memory and accumulator models, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    bus.mem_readdata = memarr.exists(bus.mem_address) ? memarr[bus.mem_address] : 32'hBAD0BAD0;
    bus.mem_waitrequest = bus.mem_read && mem_rand && ($urandom_range(0, 2) == 0);
    bus.acc_readdata = acc_res;
    if (bus.acc_read) begin
      bus.acc_waitrequest = (res_stall_cnt < res_stall_n);
      if (bus.acc_waitrequest) res_stall_cnt++;
    end else if (bus.acc_write && !bus.acc_address)
      bus.acc_waitrequest = (acc_mode == 2) || (acc_mode == 1 && $urandom_range(0, 1) == 1);
    else
      bus.acc_waitrequest = 1'b0;
  end

  // Monitor on the falling edge: log accepted transfers, check protocol.
  logic p_mh = 0, p_ah = 0, p_aw = 0, p_ar = 0, p_aa = 0;
  logic [31:0] p_ma = 0, p_ad = 0;
  always @(negedge clk) begin
    if (reset) begin
      p_mh = 1'b0;
      p_ah = 1'b0;
    end else begin
      if (p_mh && (bus.mem_read !== 1'b1 || bus.mem_address !== p_ma)) proto_err++;
      if (p_ah && (bus.acc_write !== p_aw || bus.acc_read !== p_ar ||
                   bus.acc_address !== p_aa || bus.acc_writedata !== p_ad)) proto_err++;
      if (int'(bus.mem_read) + int'(bus.acc_write) + int'(bus.acc_read) > 1) proto_err++;
      if (bus.mem_read && !bus.mem_waitrequest) obs_mem.push_back(bus.mem_address);
      if (bus.acc_write && !bus.acc_waitrequest) obs_acc.push_back({bus.acc_address, bus.acc_writedata});
      if (bus.acc_read && !bus.acc_waitrequest) obs_res_n++;
      if (clr_rel < 0 && bus.acc_write && bus.acc_address) clr_rel = cyc - c0;
      if (fetch0_rel < 0 && bus.mem_read) fetch0_rel = cyc - c0;
      p_mh = bus.mem_read && bus.mem_waitrequest;
      p_ma = bus.mem_address;
      p_ah = (bus.acc_write || bus.acc_read) && bus.acc_waitrequest;
      p_aw = bus.acc_write;
      p_ar = bus.acc_read;
      p_aa = bus.acc_address;
      p_ad = bus.acc_writedata;
    end
  end

  task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ctl_address = a; bus.ctl_writedata = d; bus.ctl_write = 1'b1;
    @(negedge clk);
    bus.ctl_write = 1'b0;
  endtask

  task automatic ctl_rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.ctl_address = a; bus.ctl_read = 1'b1;
    #1 v = bus.ctl_readdata;
    bus.ctl_read = 1'b0;
  endtask

  // Program BASE/LEN, then write start; c0 marks the cycle of the start write.
  task automatic start_job(input logic [31:0] base, input logic [31:0] len);
    ctl_wr(2'd0, base);
    ctl_wr(2'd1, len);
    obs_acc.delete(); obs_mem.delete();
    obs_res_n = 0; clr_rel = -1; fetch0_rel = -1; res_stall_cnt = 0;
    @(negedge clk);
    c0 = cyc;
    bus.ctl_address = 2'd2; bus.ctl_writedata = 32'h1; bus.ctl_write = 1'b1;
    @(negedge clk);
    bus.ctl_write = 1'b0;
  endtask

  task automatic wait_done(output int rel);
    rel = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.irq) begin
        rel = cyc - c0;
        break;
      end
    end
    if (rel < 0) begin
      n_vec++; n_err++;
      $display("FAIL job_timeout irq never rose");
    end
  endtask

  task automatic load_s1();
    logic [31:0] w [4];
    w[0] = 32'h40a00000; w[1] = 32'h41200000; w[2] = 32'h41700000; w[3] = 32'h41a00000;
    acc_res = 32'h42480000;
    exp_acc.delete(); exp_mem.delete();
    exp_acc.push_back({1'b1, 32'h0});
    for (int k = 0; k < 4; k++) begin
      memarr[32'h1000 + 32'(4 * k)] = w[k];
      exp_acc.push_back({1'b0, w[k]});
      exp_mem.push_back(32'h1000 + 32'(4 * k));
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_vec++; if ({bus.irq, bus.mem_read, bus.acc_write, bus.acc_read, bus.acc_address} !== 5'b0) begin
      n_err++; $display("FAIL rst_strobes got %b want 00000", {bus.irq, bus.mem_read, bus.acc_write, bus.acc_read, bus.acc_address}); end
    n_vec++; if ({bus.mem_address, bus.acc_writedata} !== 64'h0) begin
      n_err++; $display("FAIL rst_addr_data got %h %h want 0 0", bus.mem_address, bus.acc_writedata); end
    for (int a = 0; a < 4; a++) begin
      ctl_rd(2'(a), v);
      n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_reg%0d got %h want 0", a, v); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] v; int rel; logic [32:0] e, o; logic [31:0] em, om;
    load_s1();
    start_job(32'h1003, 32'hABCD0004);
    wait_done(rel);
    n_vec++; if (rel !== 12) begin n_err++; $display("FAIL basic_done_cycle got %0d want 12", rel); end
    n_vec++; if (clr_rel !== 1) begin n_err++; $display("FAIL basic_clr_cycle got %0d want 1", clr_rel); end
    n_vec++; if (fetch0_rel !== 2) begin n_err++; $display("FAIL basic_fetch0_cycle got %0d want 2", fetch0_rel); end
    n_vec++; if (obs_acc.size() != exp_acc.size()) begin
      n_err++; $display("FAIL basic_acc_count got %0d want %0d", obs_acc.size(), exp_acc.size()); end
    while (exp_acc.size() > 0 && obs_acc.size() > 0) begin
      e = exp_acc.pop_front(); o = obs_acc.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL basic_acc_write got %h want %h", o, e); end
    end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front();
      n_vec++; if (om !== em) begin n_err++; $display("FAIL basic_mem_addr got %h want %h", om, em); end
    end
    ctl_rd(2'd3, v);
    n_vec++; if (v !== 32'h42480000) begin n_err++; $display("FAIL basic_result got %h want 42480000", v); end
    ctl_rd(2'd2, v);
    n_vec++; if (v !== 32'h2) begin n_err++; $display("FAIL basic_status got %h want 2", v); end
    ctl_rd(2'd0, v);
    n_vec++; if (v !== 32'h1000) begin n_err++; $display("FAIL basic_base_rd got %h want 1000", v); end
    ctl_rd(2'd1, v);
    n_vec++; if (v !== 32'h4) begin n_err++; $display("FAIL basic_len_rd got %h want 4", v); end
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL basic_irq got %b want 1", bus.irq); end
    n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL basic_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_len0();
    logic [31:0] v; int rel; logic [32:0] o;
    acc_res = 32'h3f800000;
    start_job(32'h1000, 32'h0);
    wait_done(rel);
    n_vec++; if (rel !== 4) begin n_err++; $display("FAIL len0_done_cycle got %0d want 4", rel); end
    n_vec++; if (obs_mem.size() != 0) begin n_err++; $display("FAIL len0_mem_reads got %0d want 0", obs_mem.size()); end
    n_vec++; if (obs_acc.size() != 1) begin n_err++; $display("FAIL len0_acc_count got %0d want 1", obs_acc.size()); end
    else begin
      o = obs_acc.pop_front();
      n_vec++; if (o !== {1'b1, 32'h0}) begin n_err++; $display("FAIL len0_clr got %h want 100000000", o); end
    end
    n_vec++; if (obs_res_n !== 1) begin n_err++; $display("FAIL len0_res_reads got %0d want 1", obs_res_n); end
    ctl_rd(2'd3, v);
    n_vec++; if (v !== 32'h3f800000) begin n_err++; $display("FAIL len0_result got %h want 3f800000", v); end
  endtask

  task automatic test_stall();
    logic [31:0] v; int rel; logic [32:0] e, o;
    load_s1();
    acc_mode = 1; mem_rand = 1'b1; res_stall_n = 5;
    start_job(32'h1000, 32'h4);
    wait_done(rel);
    acc_mode = 0; mem_rand = 1'b0; res_stall_n = 0;
    n_vec++; if (rel < 17) begin n_err++; $display("FAIL stall_done_cycle got %0d want >=17", rel); end
    n_vec++; if (res_stall_cnt !== 5) begin n_err++; $display("FAIL stall_res_cycles got %0d want 5", res_stall_cnt); end
    n_vec++; if (obs_acc.size() != exp_acc.size()) begin
      n_err++; $display("FAIL stall_acc_count got %0d want %0d", obs_acc.size(), exp_acc.size()); end
    while (exp_acc.size() > 0 && obs_acc.size() > 0) begin
      e = exp_acc.pop_front(); o = obs_acc.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL stall_acc_write got %h want %h", o, e); end
    end
    ctl_rd(2'd3, v);
    n_vec++; if (v !== 32'h42480000) begin n_err++; $display("FAIL stall_result got %h want 42480000", v); end
    n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL stall_protocol got %0d want 0", proto_err); end
  endtask

  task automatic test_midjob();
    logic [31:0] v; int rel; logic [31:0] em, om;
    load_s1();
    start_job(32'h1000, 32'h4);
    ctl_rd(2'd2, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL midjob_status got %h want 1", v); end
    ctl_wr(2'd0, 32'h2000);
    ctl_wr(2'd2, 32'h1);
    wait_done(rel);
    n_vec++; if (rel !== 12) begin n_err++; $display("FAIL midjob_done_cycle got %0d want 12", rel); end
    n_vec++; if (obs_mem.size() != exp_mem.size()) begin
      n_err++; $display("FAIL midjob_mem_count got %0d want %0d", obs_mem.size(), exp_mem.size()); end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front();
      n_vec++; if (om !== em) begin n_err++; $display("FAIL midjob_mem_addr got %h want %h", om, em); end
    end
    ctl_rd(2'd0, v);
    n_vec++; if (v !== 32'h1000) begin n_err++; $display("FAIL midjob_base got %h want 1000", v); end
  endtask

  task automatic test_wrap();
    int rel; logic [32:0] e, o; logic [31:0] em, om;
    logic [31:0] a [3];
    a[0] = 32'hFFFFFFF8; a[1] = 32'hFFFFFFFC; a[2] = 32'h00000000;
    exp_acc.delete(); exp_mem.delete();
    exp_acc.push_back({1'b1, 32'h0});
    for (int k = 0; k < 3; k++) begin
      memarr[a[k]] = 32'h3f000000 + 32'(k);
      exp_mem.push_back(a[k]);
      exp_acc.push_back({1'b0, 32'h3f000000 + 32'(k)});
    end
    start_job(32'hFFFFFFF8, 32'h3);
    wait_done(rel);
    n_vec++; if (rel !== 10) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 10", rel); end
    n_vec++; if (obs_mem.size() != 3) begin n_err++; $display("FAIL wrap_mem_count got %0d want 3", obs_mem.size()); end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front();
      n_vec++; if (om !== em) begin n_err++; $display("FAIL wrap_mem_addr got %h want %h", om, em); end
    end
    while (exp_acc.size() > 0 && obs_acc.size() > 0) begin
      e = exp_acc.pop_front(); o = obs_acc.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL wrap_acc_write got %h want %h", o, e); end
    end
  endtask

  task automatic test_midreset();
    logic [31:0] v; int rel, n; logic [32:0] e, o;
    load_s1();
    acc_mode = 2;
    start_job(32'h1000, 32'h4);
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (bus.acc_write && !bus.acc_address) n++;
    end
    n_vec++; if (n !== 2) begin n_err++; $display("FAIL mrst_reach_push got %0d want 2", n); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.irq, bus.mem_read, bus.acc_write, bus.acc_read, bus.acc_address} !== 5'b0) begin
      n_err++; $display("FAIL mrst_strobes got %b want 00000", {bus.irq, bus.mem_read, bus.acc_write, bus.acc_read, bus.acc_address}); end
    n_vec++; if ({bus.mem_address, bus.acc_writedata} !== 64'h0) begin
      n_err++; $display("FAIL mrst_addr_data got %h %h want 0 0", bus.mem_address, bus.acc_writedata); end
    for (int a = 0; a < 4; a++) begin
      ctl_rd(2'(a), v);
      n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL mrst_reg%0d got %h want 0", a, v); end
    end
    acc_mode = 0;
    reset = 1'b0;
    load_s1();
    start_job(32'h1000, 32'h4);
    wait_done(rel);
    n_vec++; if (rel !== 12) begin n_err++; $display("FAIL mrst_rerun_cycle got %0d want 12", rel); end
    n_vec++; if (obs_acc.size() != exp_acc.size()) begin
      n_err++; $display("FAIL mrst_acc_count got %0d want %0d", obs_acc.size(), exp_acc.size()); end
    while (exp_acc.size() > 0 && obs_acc.size() > 0) begin
      e = exp_acc.pop_front(); o = obs_acc.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL mrst_acc_write got %h want %h", o, e); end
    end
    ctl_rd(2'd3, v);
    n_vec++; if (v !== 32'h42480000) begin n_err++; $display("FAIL mrst_result got %h want 42480000", v); end
  endtask

  initial begin
    bus.ctl_address = '0; bus.ctl_write = 1'b0; bus.ctl_read = 1'b0; bus.ctl_writedata = '0;
    bus.mem_readdata = '0; bus.mem_waitrequest = 1'b0;
    bus.acc_readdata = '0; bus.acc_waitrequest = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_midjob();
    test_wrap();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/float_stream_feeder.md
# float_stream_feeder

Avalon-MM front end for the CORDIC accumulator peripheral. The CPU programs a base address and element count. The block then runs one complete job without further CPU involvement:
- clears the accumulator;
- streams IEEE-754 single-precision words from memory into the accumulator's data port;
- reads back the accumulated result, latches it, and raises an interrupt.

It sits between the system interconnect and the accumulator slave, taking over the write/read sequence the CPU would otherwise issue itself.

## Interface
Parameters:
- `LEN_W`, 16, width of the element-count register; the maximum job is 2^LEN_W−1 words.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ctl_address`  in  2  control slave word address.
- `ctl_write`  in  1  control slave write strobe.
- `ctl_read`  in  1  control slave read strobe. Read latency is 0: `ctl_readdata` is combinational from `ctl_address`.
- `ctl_writedata`  in  32  control slave write data.
- `ctl_readdata`  out  32  control slave read data.
- `mem_address`  out  32  memory master byte address.
- `mem_read`  out  1  memory master read request.
- `mem_readdata`  in  32  memory read data; valid in a cycle where `mem_read` is high and `mem_waitrequest` is low.
- `mem_waitrequest`  in  1  memory stall.
- `acc_address`  out  1  accumulator slave address: 0 = data, 1 = accumulator/result.
- `acc_write`  out  1  accumulator write strobe.
- `acc_read`  out  1  accumulator read strobe.
- `acc_writedata`  out  32  word written to the accumulator.
- `acc_readdata`  in  32  accumulator result; valid in a cycle where `acc_read` is high and `acc_waitrequest` is low.
- `acc_waitrequest`  in  1  accumulator stall; it stays high while the result is not ready.
- `irq`  out  1  level interrupt; held high while `done` is set.

## Operation
Control registers, by word address:
- 0 BASE (RW): byte address of element 0. Bits [1:0] are forced to 0 on write.
- 1 LEN (RW): element count, in `LEN_W` bits; upper bits of the write are ignored and read back as 0.
- 2 CTRL/STATUS:
  - Write: bit0 = start, bit1 = clear `done`.
  - Read: bit0 = busy, bit1 = done.
- 3 RESULT (RO): last result captured from the accumulator.

FSM states:
- IDLE → CLR when start=1 and not busy. The same write also clears `done`. A start while busy is ignored, and so are writes to BASE/LEN while busy.
- CLR: drive `acc_write`=1, `acc_address`=1, `acc_writedata`=0. Hold until `acc_waitrequest`=0.
  - If LEN=0 → RES.
  - Otherwise load the element index i=0 and go → FETCH.
- FETCH: drive `mem_read`=1, `mem_address`=BASE+4·i (32-bit wrap-around). Hold until `mem_waitrequest`=0, capture `mem_readdata`, → PUSH.
- PUSH: drive `acc_write`=1, `acc_address`=0, `acc_writedata`=captured word. Hold until `acc_waitrequest`=0, then i←i+1.
  - If i+1==LEN → RES.
  - Otherwise → FETCH.
- RES: drive `acc_read`=1, `acc_address`=1. Hold until `acc_waitrequest`=0. RESULT←`acc_readdata`; → DONE.
- DONE: set `done`, → IDLE.

Master rules:
- All master outputs are registered.
- Address, data and strobe are held stable while waitrequest is high.
- At most one of `mem_read`, `acc_write`, `acc_read` is high in any cycle when the prefetch option is off.

Data words pass through unmodified; the block does no float arithmetic.

Clear-done and start in the same write: start takes effect and `done` ends at 0.

## Timing
Reset values:
- BASE=0, LEN=0, RESULT=0, busy=0, done=0, `irq`=0.
- All master strobes 0, `mem_address`=0, `acc_address`=0, `acc_writedata`=0.

Latency, with zero waitrequest and without prefetch, for a start written in cycle 0:
- CLR strobe in cycle 1.
- Element k: FETCH in cycle 2+2k, PUSH in cycle 3+2k.
- RES in cycle 2+2·LEN.
- `done`/`irq` high from cycle 4+2·LEN.

Each cycle of waitrequest adds exactly one cycle to the stage it stalls.

busy is high from cycle 1 until the cycle `done` rises.

Reset asserted mid-job:
- All state returns to reset values on the next edge.
- Any in-flight strobe drops immediately; no partial transfer is completed.

## Configuration
- `FEEDER_PREFETCH_EN` defined:
  - A 2-entry FIFO sits between the memory master and the accumulator master.
  - FETCH issues while the FIFO is not full and fetched count < LEN.
  - PUSH drains the FIFO concurrently.
  - `mem_read` and `acc_write` may be high in the same cycle.
  - With zero waitrequest, steady state is 1 element/cycle, and `done` rises by cycle 5+LEN.
  - Push order equals fetch order.
  - RES starts only after all LEN pushes complete and the FIFO is empty.
- Not defined: the strict FETCH/PUSH alternation described above, and no FIFO storage.

## Test plan
1. Memory at 0x1000 = 0x40a00000, 0x41200000, 0x41700000, 0x41a00000; BASE=0x1000, LEN=4, start; the accumulator model returns 0x42480000 → accumulator sees write(1,0) then data writes in that order; RESULT=0x42480000; `irq`=1; STATUS=0x2.
2. LEN=0, start → one CLR write then a read; no `mem_read`; `done` set at cycle 4.
3. Same as scenario 1 with `acc_waitrequest` held high for 5 cycles on the result read and randomly on data writes → identical write sequence, stable strobes while stalled, RESULT correct.
4. Start issued again mid-job, and a BASE write mid-job → both ignored; the job completes with the original BASE; STATUS reads 0x1 while busy.
5. BASE=0xFFFFFFF8, LEN=3 → memory addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. Reset asserted 2 cycles into PUSH → all outputs at their reset values on the next edge; a fresh start afterwards runs a full job normally.
